// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational ALU between two requesters.
// One operation is in flight at a time. An accepted request is registered onto
// the ALU input ports, the ALU result is captured one cycle later, and it is
// returned to the requester that owns the operation over a valid/ready channel.
//
// Parameters:
//   N          operand/result width
//   FIXED_PRIO 1: requester 0 always wins contention; 0: round-robin
//
// Optional feature macro: ALU_ARB_ILLEGAL_OP_EN
//   When defined, an accepted request with an opcode outside the legal set
//   bypasses the ALU. It is answered one cycle after accept with data=0 and
//   err=1, and the ALU input registers keep their previous values.
//   When undefined, every opcode goes through the ALU and err stays 0.
//
// Ports:
//   i_clk, i_rst_n                  clock, asynchronous active-low reset
//   i_reqX_valid / o_reqX_ready     request handshake (X = 0, 1)
//   i_reqX_op_a/op_b/alu_op         request payload
//   o_rspX_valid / i_rspX_ready     response handshake
//   o_rspX_data, o_rspX_err         response payload
//   o_alu_op_a/op_b/op              registered ALU inputs
//   i_alu_data                      ALU result, combinational from o_alu_*
module alu_arbiter #(
  parameter int unsigned N          = 32,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic         i_clk,
  input  logic         i_rst_n,

  input  logic         i_req0_valid,
  output logic         o_req0_ready,
  input  logic [N-1:0] i_req0_op_a,
  input  logic [N-1:0] i_req0_op_b,
  input  logic [3:0]   i_req0_alu_op,

  input  logic         i_req1_valid,
  output logic         o_req1_ready,
  input  logic [N-1:0] i_req1_op_a,
  input  logic [N-1:0] i_req1_op_b,
  input  logic [3:0]   i_req1_alu_op,

  output logic         o_rsp0_valid,
  input  logic         i_rsp0_ready,
  output logic [N-1:0] o_rsp0_data,
  output logic         o_rsp0_err,

  output logic         o_rsp1_valid,
  input  logic         i_rsp1_ready,
  output logic [N-1:0] o_rsp1_data,
  output logic         o_rsp1_err,

  output logic [N-1:0] o_alu_op_a,
  output logic [N-1:0] o_alu_op_b,
  output logic [3:0]   o_alu_op,
  input  logic [N-1:0] i_alu_data
);

  localparam int unsigned OP_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            last_grant_q, last_grant_d;
  logic            owner_q, owner_d;
  logic [N-1:0]    alu_a_q, alu_a_d;
  logic [N-1:0]    alu_b_q, alu_b_d;
  logic [OP_W-1:0] alu_op_q, alu_op_d;
  logic [1:0]      rsp_valid_q, rsp_valid_d;
  logic [1:0]      rsp_err_q, rsp_err_d;
  logic [N-1:0]    rsp0_data_q, rsp0_data_d;
  logic [N-1:0]    rsp1_data_q, rsp1_data_d;

  logic            grant_c;
  logic            accept_c;
  logic            skip_exec_c;
  logic            rsp_hs_c;
  logic [N-1:0]    sel_a_c;
  logic [N-1:0]    sel_b_c;
  logic [OP_W-1:0] sel_op_c;

`ifdef ALU_ARB_ILLEGAL_OP_EN
  // Legal set: 0000-0110 and 1000-1010.
  function automatic logic is_illegal(input logic [OP_W-1:0] op);
    return (op == OP_W'(7)) || (op > OP_W'(10));
  endfunction
`endif

  // Grant selection; only meaningful while IDLE with at least one valid.
  always_comb begin
    grant_c = 1'b0;
    if (i_req0_valid && i_req1_valid) begin
      grant_c = FIXED_PRIO ? 1'b0 : ~last_grant_q;
    end else if (i_req1_valid) begin
      grant_c = 1'b1;
    end
  end

  assign o_req0_ready = (state_q == ST_IDLE) && i_req0_valid && !grant_c;
  assign o_req1_ready = (state_q == ST_IDLE) && i_req1_valid &&  grant_c;
  assign accept_c     = (state_q == ST_IDLE) && (i_req0_valid || i_req1_valid);

  // Payload of the granted requester.
  assign sel_a_c  = grant_c ? i_req1_op_a   : i_req0_op_a;
  assign sel_b_c  = grant_c ? i_req1_op_b   : i_req0_op_b;
  assign sel_op_c = grant_c ? i_req1_alu_op : i_req0_alu_op;

`ifdef ALU_ARB_ILLEGAL_OP_EN
  assign skip_exec_c = is_illegal(sel_op_c);
`else
  assign skip_exec_c = 1'b0;
`endif

  // Response handshake on the owner's channel.
  assign rsp_hs_c = owner_q ? (rsp_valid_q[1] && i_rsp1_ready)
                            : (rsp_valid_q[0] && i_rsp0_ready);

  // Next-state and datapath updates.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_err_d    = rsp_err_q;
    rsp0_data_d  = rsp0_data_q;
    rsp1_data_d  = rsp1_data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          owner_d      = grant_c;
          last_grant_d = grant_c;
          if (skip_exec_c) begin
            // Answer directly; the ALU inputs are left untouched.
            state_d              = ST_RESP;
            rsp_valid_d[grant_c] = 1'b1;
            rsp_err_d[grant_c]   = 1'b1;
            if (grant_c) rsp1_data_d = '0;
            else         rsp0_data_d = '0;
          end else begin
            state_d  = ST_EXEC;
            alu_a_d  = sel_a_c;
            alu_b_d  = sel_b_c;
            alu_op_d = sel_op_c;
          end
        end
      end
      ST_EXEC: begin
        state_d              = ST_RESP;
        rsp_valid_d[owner_q] = 1'b1;
        rsp_err_d[owner_q]   = 1'b0;
        if (owner_q) rsp1_data_d = i_alu_data;
        else         rsp0_data_d = i_alu_data;
      end
      ST_RESP: begin
        // Data and err stay frozen until the owner takes the response.
        if (rsp_hs_c) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 2'b00;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 2'b00;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      rsp_valid_q  <= 2'b00;
      rsp_err_q    <= 2'b00;
      rsp0_data_q  <= '0;
      rsp1_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_err_q    <= rsp_err_d;
      rsp0_data_q  <= rsp0_data_d;
      rsp1_data_q  <= rsp1_data_d;
    end
  end

  assign o_alu_op_a   = alu_a_q;
  assign o_alu_op_b   = alu_b_q;
  assign o_alu_op     = alu_op_q;
  assign o_rsp0_valid = rsp_valid_q[0];
  assign o_rsp1_valid = rsp_valid_q[1];
  assign o_rsp0_data  = rsp0_data_q;
  assign o_rsp1_data  = rsp1_data_q;
  assign o_rsp0_err   = rsp_err_q[0];
  assign o_rsp1_err   = rsp_err_q[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: a round-robin instance (u_rr) and a
// fixed-priority instance (u_fp) share the request stimulus; each has its own
// behavioural ALU. Directed scenarios are followed by a randomized phase
// checked against a cycle-level reference model of the arbiter.
module tb_alu_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        v0, v1, rr0, rr1;
  logic [31:0] a0, b0, a1, b1;
  logic [3:0]  op0, op1;

  logic        rdy0, rdy1, rv0, rv1, re0, re1;
  logic [31:0] rd0, rd1, alu_a, alu_b, alu_data;
  logic [3:0]  alu_op;

  logic        rdy0_f, rdy1_f, rv0_f, rv1_f, re0_f, re1_f;
  logic [31:0] rd0_f, rd1_f, alu_a_f, alu_b_f, alu_data_f;
  logic [3:0]  alu_op_f;

  int n_assert = 0;
  int n_fail   = 0;

  logic [3:0] legal_ops [10] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10};

  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd3:    return (a < b) ? 32'd1 : 32'd0;
      4'd4:    return a << b[4:0];
      4'd5:    return a >> b[4:0];
      4'd6:    return 32'($signed(a) >>> b[4:0]);
      4'd8:    return a ^ b;
      4'd9:    return a | b;
      4'd10:   return a & b;
      default: return 32'd0;
    endcase
  endfunction

  always_comb alu_data   = alu_ref(alu_op, alu_a, alu_b);
  always_comb alu_data_f = alu_ref(alu_op_f, alu_a_f, alu_b_f);

  alu_arbiter #(.N(32), .FIXED_PRIO(1'b0)) u_rr (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req0_valid(v0), .o_req0_ready(rdy0), .i_req0_op_a(a0), .i_req0_op_b(b0), .i_req0_alu_op(op0),
    .i_req1_valid(v1), .o_req1_ready(rdy1), .i_req1_op_a(a1), .i_req1_op_b(b1), .i_req1_alu_op(op1),
    .o_rsp0_valid(rv0), .i_rsp0_ready(rr0), .o_rsp0_data(rd0), .o_rsp0_err(re0),
    .o_rsp1_valid(rv1), .i_rsp1_ready(rr1), .o_rsp1_data(rd1), .o_rsp1_err(re1),
    .o_alu_op_a(alu_a), .o_alu_op_b(alu_b), .o_alu_op(alu_op), .i_alu_data(alu_data)
  );

  alu_arbiter #(.N(32), .FIXED_PRIO(1'b1)) u_fp (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req0_valid(v0), .o_req0_ready(rdy0_f), .i_req0_op_a(a0), .i_req0_op_b(b0), .i_req0_alu_op(op0),
    .i_req1_valid(v1), .o_req1_ready(rdy1_f), .i_req1_op_a(a1), .i_req1_op_b(b1), .i_req1_alu_op(op1),
    .o_rsp0_valid(rv0_f), .i_rsp0_ready(rr0), .o_rsp0_data(rd0_f), .o_rsp0_err(re0_f),
    .o_rsp1_valid(rv1_f), .i_rsp1_ready(rr1), .o_rsp1_data(rd1_f), .o_rsp1_err(re1_f),
    .o_alu_op_a(alu_a_f), .o_alu_op_b(alu_b_f), .o_alu_op(alu_op_f), .i_alu_data(alu_data_f)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs are driven 1 time unit after the rising edge and checked 1 unit later.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_inputs();
    v0 = 0; v1 = 0; rr0 = 0; rr1 = 0;
    a0 = 0; b0 = 0; op0 = 0; a1 = 0; b1 = 0; op1 = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    i_rst_n = 1'b0;
    tick();
    tick();
    i_rst_n = 1'b1;
  endtask

  // Reference-model state for the randomized phase.
  bit          busy, p_own, last_m, w, acc, done;
  logic [31:0] p_data;
  int          p_age, k, ph;

  initial begin
    i_rst_n = 1'b0;
    clear_inputs();
    tick();
    tick();
    #1;
    // Reset values.
    chk("rst_rdy0", rdy0, 0);
    chk("rst_rv0", rv0, 0);
    chk("rst_rv1", rv1, 0);
    chk("rst_rd0", rd0, 0);
    chk("rst_rd1", rd1, 0);
    chk("rst_err", {re1, re0}, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_op", alu_op, 0);
    tick();
    i_rst_n = 1'b1;

    // Single request: ADD 5+3 from req0.
    v0 = 1; a0 = 5; b0 = 3; op0 = 4'd0; rr0 = 1; rr1 = 1;
    #1;
    chk("t1_rdy0_c0", rdy0, 1);
    chk("t1_rdy1_c0", rdy1, 0);
    tick();
    v0 = 0;
    #1;
    chk("t1_rv0_c1", rv0, 0);
    chk("t1_alu_a", alu_a, 5);
    chk("t1_alu_b", alu_b, 3);
    chk("t1_alu_op", alu_op, 0);
    tick();
    #1;
    chk("t1_rv0_c2", rv0, 1);
    chk("t1_rd0", rd0, 8);
    chk("t1_re0", re0, 0);
    chk("t1_rv1", rv1, 0);
    tick();
    #1;
    chk("t1_rv0_c3", rv0, 0);

    // Contention: req0 SUB 10-4, req1 SLT -1<1, both valid throughout.
    do_reset();
    v0 = 1; a0 = 10; b0 = 4; op0 = 4'd1;
    v1 = 1; a1 = 32'hFFFF_FFFF; b1 = 1; op1 = 4'd2;
    rr0 = 1; rr1 = 1;
    for (int c = 0; c < 9; c++) begin
      k  = c / 3;
      ph = c % 3;
      w  = k[0];
      #1;
      case (ph)
        0: begin
          chk("t2_rdy0", rdy0, 32'(!w));
          chk("t2_rdy1", rdy1, 32'(w));
          chk("t2_fp_rdy0", rdy0_f, 1);
          chk("t2_fp_rdy1", rdy1_f, 0);
        end
        1: begin
          chk("t2_exec_rdy", {rdy1, rdy0}, 0);
          chk("t2_exec_rv", {rv1, rv0}, 0);
        end
        default: begin
          chk("t2_rv0", rv0, 32'(!w));
          chk("t2_rv1", rv1, 32'(w));
          chk("t2_data", w ? rd1 : rd0, w ? 32'd1 : 32'd6);
          chk("t2_fp_rv0", rv0_f, 1);
          chk("t2_fp_rv1", rv1_f, 0);
          chk("t2_fp_rd0", rd0_f, 6);
        end
      endcase
      tick();
    end

    // Back-pressured response: req1 SRA 0x80000000 by 4, rsp1 stalled 5 cycles.
    do_reset();
    v1 = 1; a1 = 32'h8000_0000; b1 = 4; op1 = 4'd6; rr0 = 1; rr1 = 0;
    #1;
    chk("t3_rdy1", rdy1, 1);
    tick();
    v1 = 0; v0 = 1; a0 = 1; b0 = 1; op0 = 4'd0;
    #1;
    chk("t3_exec_rdy0", rdy0, 0);
    tick();
    for (int c = 0; c < 5; c++) begin
      a1 = $urandom; op1 = legal_ops[$urandom_range(0, 9)];
      #1;
      chk("t3_stall_rv1", rv1, 1);
      chk("t3_stall_rd1", rd1, 32'hF800_0000);
      chk("t3_stall_rdy0", rdy0, 0);
      tick();
    end
    rr1 = 1;
    #1;
    chk("t3_hs_rv1", rv1, 1);
    tick();
    #1;
    chk("t3_post_rv1", rv1, 0);
    chk("t3_post_rdy0", rdy0, 1);
    tick();
    v0 = 0;
    tick();
    #1;
    chk("t3_add_rv0", rv0, 1);
    chk("t3_add_rd0", rd0, 2);
    tick();

    // Illegal opcode 1100 from req0; ALU inputs currently hold 1, 1, ADD.
    v0 = 1; a0 = 7; b0 = 9; op0 = 4'b1100;
    #1;
    chk("t4_rdy0", rdy0, 1);
    tick();
    v0 = 0;
    #1;
`ifdef ALU_ARB_ILLEGAL_OP_EN
    chk("t4_rv0_c1", rv0, 1);
    chk("t4_rd0", rd0, 0);
    chk("t4_re0", re0, 1);
    chk("t4_alu_a_kept", alu_a, 1);
    chk("t4_alu_op_kept", alu_op, 0);
    tick();
`else
    chk("t4_rv0_c1", rv0, 0);
    chk("t4_alu_a", alu_a, 7);
    chk("t4_alu_op", alu_op, 4'b1100);
    tick();
    #1;
    chk("t4_rv0_c2", rv0, 1);
    chk("t4_rd0", rd0, 0);
    chk("t4_re0", re0, 0);
    tick();
`endif
    #1;
    chk("t4_done_rv0", rv0, 0);

    // Reset during EXEC drops the operation.
    v0 = 1; a0 = 3; b0 = 4; op0 = 4'd0;
    tick();
    v0 = 0;
    #1;
    chk("t5_pre_alu_a", alu_a, 3);
    i_rst_n = 1'b0;
    #1;
    chk("t5_rst_alu_a", alu_a, 0);
    chk("t5_rst_alu_op", alu_op, 0);
    chk("t5_rst_rv", {rv1, rv0}, 0);
    chk("t5_rst_rdy", {rdy1, rdy0}, 0);
    tick();
    i_rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("t5_no_rsp", {rv1, rv0}, 0);
      tick();
    end

    // Randomized traffic against the reference model (round-robin instance).
    do_reset();
    busy = 0; last_m = 1; p_age = 0; p_own = 0; p_data = 0; done = 0; acc = 0; w = 0;
    for (int c = 0; c < 400; c++) begin
      v0 = 1'($urandom_range(0, 1)); v1 = 1'($urandom_range(0, 1));
      a0 = $urandom; b0 = $urandom; op0 = legal_ops[$urandom_range(0, 9)];
      a1 = $urandom; b1 = $urandom; op1 = legal_ops[$urandom_range(0, 9)];
      rr0 = 1'($urandom_range(0, 1)); rr1 = 1'($urandom_range(0, 1));
      #1;
      acc = 0; done = 0;
      if (!busy) begin
        if (v0 && v1) w = ~last_m;
        else          w = v1;
        chk("rnd_rdy0", rdy0, 32'(v0 && !w));
        chk("rnd_rdy1", rdy1, 32'(v1 && w));
        chk("rnd_idle_rv", {rv1, rv0}, 0);
        acc = v0 || v1;
        if (acc) begin
          p_own  = w;
          p_data = w ? alu_ref(op1, a1, b1) : alu_ref(op0, a0, b0);
        end
      end else if (p_age == 1) begin
        chk("rnd_exec_rdy", {rdy1, rdy0}, 0);
        chk("rnd_exec_rv", {rv1, rv0}, 0);
      end else begin
        chk("rnd_resp_rdy", {rdy1, rdy0}, 0);
        chk("rnd_rv0", rv0, 32'(!p_own));
        chk("rnd_rv1", rv1, 32'(p_own));
        chk("rnd_data", p_own ? rd1 : rd0, p_data);
        done = p_own ? rr1 : rr0;
      end
      tick();
      if (!busy) begin
        if (acc) begin
          busy   = 1;
          p_age  = 1;
          last_m = w;
        end
      end else if (p_age >= 2 && done) begin
        busy = 0;
      end else begin
        p_age++;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
